ls_exec: RTL and testbench
==========================

# ls_exec

Load/store execution unit directly downstream of the load/store buffer. It takes one issued memory op at a time, computes the effective address, and runs a request/done handshake with the memory controller. It then retires the op by pulsing `LSdone` to the buffer and, for loads, broadcasting the extended result on the LS write-back bus consumed by every reservation-station line.

## Interface
Parameters:
- `DATA_W`, 32, data/address width (matches `DataBus`)
- `TAG_W`, 4, rename tag width (matches `TagBus`)
- `NAME_W`, 5, architectural register name width (matches `NameBus`)
- `OP_W`, 6, opcode width (matches `OpBus`)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: clock
  - `rst` in 1: reset
- From the load/store buffer:
  - `LSworkEn` in 1: issued op valid, one-cycle pulse
  - `operandO` in DATA_W: base address
  - `operandT` in DATA_W: store data
  - `imm` in DATA_W: sign-extended offset
  - `wrtTag` in TAG_W: destination tag
  - `wrtName` in NAME_W: destination register
  - `opCode` in OP_W: one of `LB LH LW LBU LHU SB SH SW`
- To the load/store buffer:
  - `LSreadEn` out 1: unit can accept an op
  - `LSdone` out 1: op retired, one-cycle pulse
- Write-back bus:
  - `enLSwrt` out 1: load result valid
  - `LStag` out TAG_W: result tag
  - `LSdata` out DATA_W: result data
  - `LSname` out NAME_W: result register
- Memory controller:
  - `memReq` out 1: request, level
  - `memWe` out 1: 1 = store
  - `memLen` out 2: 0 = byte, 1 = half, 2 = word
  - `memAddr` out DATA_W: address
  - `memWdata` out DATA_W: store data, right-aligned
  - `memDone` in 1: request complete, one-cycle pulse
  - `memRdata` in DATA_W: load data, right-aligned, valid with `memDone`

## Operation
- FSM states: IDLE, MEM, WB.
- `LSreadEn = (state == IDLE) && !LSworkEn`. This is combinational, so the buffer cannot issue a second op in the cycle its first op arrives.
- IDLE, with `LSworkEn`:
  - latch tag, name, opcode, and the store/len/signed decode;
  - `memAddr <= operandO + imm` (mod 2^DATA_W, carry dropped); `memWdata <= operandT`;
  - `memReq <= 1`; go to MEM.
- IDLE, with `LSworkEn` carrying a non-LS opcode: treated as NOP. It gives an immediate `LSdone` pulse the next cycle with no memory access and no broadcast.
- MEM: `memReq`, `memWe`, `memLen`, `memAddr`, `memWdata` stay stable until `memDone` is sampled high. At that edge:
  - `memReq <= 0`;
  - for loads, capture the extended `memRdata`:
    - LB/LH sign-extend bit 7/15;
    - LBU/LHU zero-extend;
    - LW passes all bits.
  - Go to WB.
- WB, for one cycle:
  - `LSdone = 1`;
  - for loads: `enLSwrt = 1`, `LStag`/`LSname`/`LSdata` = latched values;
  - for stores: `enLSwrt = 0`, tag/name/data at free values.
  - Return to IDLE.
- `LSworkEn` arriving outside IDLE is a protocol violation. It is ignored; the bench flags it as an assertion.
- Reset:
  - state IDLE;
  - `memReq`, `LSdone`, `enLSwrt`, `memWe` = 0;
  - `memLen` = 0;
  - `memAddr`, `memWdata`, `LSdata` = `dataFree`;
  - `LStag` = `tagFree`; `LSname` = `nameFree`.
- Reset mid-MEM drops `memReq` immediately and discards the op; the memory controller aborts on `memReq` low.

## Timing
- `LSworkEn` in cycle t → `memReq` high in t+1 → `memDone` in t+1+k (k ≥ 0) → `LSdone`/`enLSwrt` in t+2+k → `LSreadEn` high in t+3+k.
- Minimum occupancy is 3 cycles per op; one op is in flight at most.
- All outputs except `LSreadEn` are registered.

## Configuration
- `LS_ALIGN_CHECK_EN` defined:
  - a half access with `addr[0] != 0`, or a word access with `addr[1:0] != 0`, skips MEM: `memReq` is never raised and WB happens in t+1;
  - loads broadcast `LSdata = 0`;
  - output `LSmisalign` (1 bit, reset 0) pulses together with `LSdone`.
- Undefined: no check, address passed unmodified, `LSmisalign` port absent.

## Structure
- Opcode constants `LB..SW`, `dataFree`/`tagFree`/`nameFree`, and the `memLen` encodings live in shared `defines.v`.
- One combinational sub-module, `ls_extend` (`memRdata`, len, signed → extended data), is reused by the instruction-fetch path.

## Test plan
- LW, `operandO=0x100`, `imm=0x4`, `memDone` at k=2, `memRdata=0xDEADBEEF` → `memAddr=0x104`, `memLen=2`, `enLSwrt`+`LSdone` in t+4, `LSdata=0xDEADBEEF`.
- LB/LBU, `memRdata=0x00000080` → `LSdata=0xFFFFFF80` / `0x00000080`; LH with `0x8001` → `0xFFFF8001`.
- SB, `operandT=0x12345678`, `addr=0x200` → `memWe=1`, `memLen=0`, `memWdata=0x12345678`; `LSdone` pulses with `enLSwrt=0`.
- Address wrap: `operandO=0xFFFFFFFC`, `imm=0x8` → `memAddr=0x00000004`.
- Back-to-back: buffer re-issues as soon as `LSreadEn` rises, `memDone` at k=0 → ops 3 cycles apart, no double-issue, `LSreadEn=0` in every cycle `LSworkEn=1`.
- `rst` during MEM → `memReq` low the same cycle, no `LSdone`; with `LS_ALIGN_CHECK_EN`, LW at `0x102` → no `memReq`, `LSmisalign`+`LSdone` in t+1.

Source files
------------

// File: rtl/ls_exec_pkg.sv
// ls_exec_pkg: constants shared by the load/store execution unit and its users.
//   - opcode encodings for LB LH LW LBU LHU SB SH SW
//   - memLen encodings (byte / half / word)
//   - idle ("free") values driven on the write-back and memory buses
//   - FSM state type and the opcode decode helper
package ls_exec_pkg;

    localparam logic [5:0] OP_LB  = 6'h03;
    localparam logic [5:0] OP_LH  = 6'h04;
    localparam logic [5:0] OP_LW  = 6'h05;
    localparam logic [5:0] OP_LBU = 6'h06;
    localparam logic [5:0] OP_LHU = 6'h07;
    localparam logic [5:0] OP_SB  = 6'h08;
    localparam logic [5:0] OP_SH  = 6'h09;
    localparam logic [5:0] OP_SW  = 6'h0A;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    localparam logic [31:0] DATA_FREE = 32'h0;
    localparam logic [7:0]  TAG_FREE  = 8'h0;
    localparam logic [7:0]  NAME_FREE = 8'h0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WB   = 2'd2
    } ls_state_e;

    typedef struct packed {
        logic       valid;  // opcode is a load/store
        logic       store;
        logic       sgn;    // sign-extend the load result
        logic [1:0] len;
    } ls_dec_t;

    function automatic ls_dec_t ls_decode(input logic [5:0] op);
        ls_dec_t d;
        d = '{valid: 1'b1, store: 1'b0, sgn: 1'b0, len: LEN_WORD};
        case (op)
            OP_LB:   begin d.sgn = 1'b1; d.len = LEN_BYTE; end
            OP_LH:   begin d.sgn = 1'b1; d.len = LEN_HALF; end
            OP_LW:   d.len = LEN_WORD;
            OP_LBU:  d.len = LEN_BYTE;
            OP_LHU:  d.len = LEN_HALF;
            OP_SB:   begin d.store = 1'b1; d.len = LEN_BYTE; end
            OP_SH:   begin d.store = 1'b1; d.len = LEN_HALF; end
            OP_SW:   begin d.store = 1'b1; d.len = LEN_WORD; end
            default: begin d.valid = 1'b0; d.len = LEN_BYTE; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ls_exec_extend.sv
// ls_extend: combinational load-data extension, also used by the fetch path.
// Ports:
//   rdata in  DATA_W : right-aligned memory read data
//   len   in  2      : LEN_BYTE / LEN_HALF / LEN_WORD
//   sgn   in  1      : 1 = sign-extend, 0 = zero-extend
//   ext   out DATA_W : extended result
module ls_extend
    import ls_exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        len,
    input  logic              sgn,
    output logic [DATA_W-1:0] ext
);

    always_comb begin
        ext = rdata;
        case (len)
            LEN_BYTE: ext = {{(DATA_W-8){sgn & rdata[7]}}, rdata[7:0]};
            LEN_HALF: ext = {{(DATA_W-16){sgn & rdata[15]}}, rdata[15:0]};
            default:  ext = rdata;
        endcase
    end

endmodule

// File: rtl/ls_exec.sv
// ls_exec: load/store execution unit. Takes one issued op, forms the
// effective address, runs the memReq/memDone handshake, then retires via
// LSdone and (for loads) the LS write-back bus.
// Optional feature macro: LS_ALIGN_CHECK_EN (misaligned half/word accesses
// skip memory and raise LSmisalign; adds the LSmisalign port).
// Ports:
//   clk, rst (async, active-high)
//   LSworkEn, operandO, operandT, imm, wrtTag, wrtName, opCode : issued op
//   LSreadEn, LSdone                                        : to LS buffer
//   enLSwrt, LStag, LSdata, LSname                          : write-back bus
//   memReq, memWe, memLen, memAddr, memWdata, memDone, memRdata : memory
//
// state  | meaning
// S_IDLE | ready for an op; LSreadEn high unless one is arriving
// S_MEM  | memory request outstanding, waiting for memDone
// S_WB   | one-cycle retire: LSdone (and enLSwrt for loads) high
module ls_exec
    import ls_exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int NAME_W = 5,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LSworkEn,
    input  logic [DATA_W-1:0] operandO,
    input  logic [DATA_W-1:0] operandT,
    input  logic [DATA_W-1:0] imm,
    input  logic [TAG_W-1:0]  wrtTag,
    input  logic [NAME_W-1:0] wrtName,
    input  logic [OP_W-1:0]   opCode,
    output logic              LSreadEn,
    output logic              LSdone,
    output logic              enLSwrt,
    output logic [TAG_W-1:0]  LStag,
    output logic [DATA_W-1:0] LSdata,
    output logic [NAME_W-1:0] LSname,
    output logic              memReq,
    output logic              memWe,
    output logic [1:0]        memLen,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
`ifdef LS_ALIGN_CHECK_EN
    output logic              LSmisalign,
`endif
    input  logic              memDone,
    input  logic [DATA_W-1:0] memRdata
);

    ls_state_e         state;
    ls_dec_t           dec;
    logic [DATA_W-1:0] eff_addr;
    logic [DATA_W-1:0] ext_data;
    logic [TAG_W-1:0]  lat_tag;
    logic [NAME_W-1:0] lat_name;
    logic              lat_load;
    logic              lat_sgn;

    assign dec      = ls_decode(6'(opCode));
    assign eff_addr = operandO + imm;  // wraps mod 2^DATA_W
    assign LSreadEn = (state == S_IDLE) && !LSworkEn;

`ifdef LS_ALIGN_CHECK_EN
    logic misalign;
    assign misalign = ((dec.len == LEN_HALF) && eff_addr[0]) ||
                      ((dec.len == LEN_WORD) && (eff_addr[1:0] != 2'b00));
`endif

    ls_extend #(.DATA_W(DATA_W)) u_extend (
        .rdata (memRdata),
        .len   (memLen),
        .sgn   (lat_sgn),
        .ext   (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            LSdone   <= 1'b0;
            enLSwrt  <= 1'b0;
            LStag    <= TAG_W'(TAG_FREE);
            LSname   <= NAME_W'(NAME_FREE);
            LSdata   <= DATA_W'(DATA_FREE);
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memLen   <= LEN_BYTE;
            memAddr  <= DATA_W'(DATA_FREE);
            memWdata <= DATA_W'(DATA_FREE);
            lat_tag  <= TAG_W'(TAG_FREE);
            lat_name <= NAME_W'(NAME_FREE);
            lat_load <= 1'b0;
            lat_sgn  <= 1'b0;
`ifdef LS_ALIGN_CHECK_EN
            LSmisalign <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (LSworkEn) begin
                        if (!dec.valid) begin
                            // Non-LS opcode: retire as a NOP with no access.
                            LSdone <= 1'b1;
                            state  <= S_WB;
                        end else begin
                            lat_tag  <= wrtTag;
                            lat_name <= wrtName;
                            lat_load <= !dec.store;
                            lat_sgn  <= dec.sgn;
                            memWe    <= dec.store;
                            memLen   <= dec.len;
                            memAddr  <= eff_addr;
                            memWdata <= operandT;
`ifdef LS_ALIGN_CHECK_EN
                            if (misalign) begin
                                LSdone     <= 1'b1;
                                LSmisalign <= 1'b1;
                                enLSwrt    <= !dec.store;
                                LStag      <= dec.store ? TAG_W'(TAG_FREE) : wrtTag;
                                LSname     <= dec.store ? NAME_W'(NAME_FREE) : wrtName;
                                LSdata     <= dec.store ? DATA_W'(DATA_FREE) : '0;
                                state      <= S_WB;
                            end else begin
                                memReq <= 1'b1;
                                state  <= S_MEM;
                            end
`else
                            memReq <= 1'b1;
                            state  <= S_MEM;
`endif
                        end
                    end
                end
                S_MEM: begin
                    if (memDone) begin
                        memReq  <= 1'b0;
                        LSdone  <= 1'b1;
                        enLSwrt <= lat_load;
                        LStag   <= lat_load ? lat_tag : TAG_W'(TAG_FREE);
                        LSname  <= lat_load ? lat_name : NAME_W'(NAME_FREE);
                        LSdata  <= lat_load ? ext_data : DATA_W'(DATA_FREE);
                        state   <= S_WB;
                    end
                end
                S_WB: begin
                    LSdone  <= 1'b0;
                    enLSwrt <= 1'b0;
                    LStag   <= TAG_W'(TAG_FREE);
                    LSname  <= NAME_W'(NAME_FREE);
                    LSdata  <= DATA_W'(DATA_FREE);
`ifdef LS_ALIGN_CHECK_EN
                    LSmisalign <= 1'b0;
`endif
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ls_exec.sv
module tb_ls_exec;
    import ls_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        LSworkEn;
    logic [31:0] operandO, operandT, imm;
    logic [3:0]  wrtTag;
    logic [4:0]  wrtName;
    logic [5:0]  opCode;
    logic        LSreadEn, LSdone, enLSwrt;
    logic [3:0]  LStag;
    logic [31:0] LSdata;
    logic [4:0]  LSname;
    logic        memReq, memWe;
    logic [1:0]  memLen;
    logic [31:0] memAddr, memWdata;
    logic        memDone;
    logic [31:0] memRdata;
    logic        LSmisalign;

`ifdef LS_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
    assign LSmisalign = 1'b0;
`endif

    ls_exec dut (
        .clk(clk), .rst(rst), .LSworkEn(LSworkEn), .operandO(operandO),
        .operandT(operandT), .imm(imm), .wrtTag(wrtTag), .wrtName(wrtName),
        .opCode(opCode), .LSreadEn(LSreadEn), .LSdone(LSdone),
        .enLSwrt(enLSwrt), .LStag(LStag), .LSdata(LSdata), .LSname(LSname),
        .memReq(memReq), .memWe(memWe), .memLen(memLen), .memAddr(memAddr),
        .memWdata(memWdata),
`ifdef LS_ALIGN_CHECK_EN
        .LSmisalign(LSmisalign),
`endif
        .memDone(memDone), .memRdata(memRdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_valid(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic bit ref_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic int ref_bytes(input logic [5:0] op);
        if (op inside {OP_LB, OP_LBU, OP_SB}) return 1;
        if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] ref_len(input logic [5:0] op);
        return (ref_bytes(op) == 1) ? 2'd0 : (ref_bytes(op) == 2) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [31:0] ref_addr(input logic [31:0] b, input logic [31:0] i);
        longint s;
        s = longint'(b) + longint'(i);
        return 32'(s % 64'sd4294967296);
    endfunction

    function automatic logic [31:0] ref_ext(input logic [5:0] op, input logic [31:0] r);
        longint v;
        v = longint'(r);
        case (op)
            OP_LB:  begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            OP_LH:  begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            OP_LBU: v = v % 256;
            OP_LHU: v = v % 65536;
            default: ;
        endcase
        return 32'(v);
    endfunction

    function automatic bit ref_misaligned(input logic [5:0] op, input logic [31:0] a);
        return (a % ref_bytes(op)) != 0;
    endfunction

    // ---------------- one op, end to end ----------------
    int last_issue = -100;

    task automatic do_op(input logic [5:0] op, input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wd, input logic [3:0] tg, input logic [4:0] nm,
                         input int k, input logic [31:0] rd, input bit chk_gap);
        int guard;
        int t_issue;
        logic [31:0] a;
        bit ld;
        guard = 0;
        while (!LSreadEn && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("readen_before_issue", 32'(LSreadEn), 32'd1);
        LSworkEn = 1'b1; opCode = op; operandO = base; imm = off;
        operandT = wd; wrtTag = tg; wrtName = nm;
        #1;
        check("readen_low_on_issue", 32'(LSreadEn), 32'd0);
        t_issue = cyc;
        if (chk_gap) check("issue_gap", 32'(t_issue - last_issue), 32'd3);
        last_issue = t_issue;
        a  = ref_addr(base, off);
        ld = ref_load(op);
        @(posedge clk); #1;
        LSworkEn = 1'b0;
        opCode = 6'($urandom); operandO = $urandom; imm = $urandom;
        if (!ref_valid(op)) begin
            check("nop_done", 32'(LSdone), 32'd1);
            check("nop_req", 32'(memReq), 32'd0);
            check("nop_wrt", 32'(enLSwrt), 32'd0);
        end else if (ALIGN && ref_misaligned(op, a)) begin
            check("mis_req", 32'(memReq), 32'd0);
            check("mis_done", 32'(LSdone), 32'd1);
            check("mis_flag", 32'(LSmisalign), 32'd1);
            check("mis_wrt", 32'(enLSwrt), 32'(ld));
            if (ld) check("mis_data", LSdata, 32'd0);
        end else begin
            check("req", 32'(memReq), 32'd1);
            check("addr", memAddr, a);
            check("we", 32'(memWe), 32'(!ld));
            check("len", 32'(memLen), 32'(ref_len(op)));
            check("wdata", memWdata, wd);
            check("early_done", 32'(LSdone), 32'd0);
            for (int j = 0; j < k; j++) begin
                @(posedge clk); #1;
                check("req_hold", 32'(memReq), 32'd1);
                check("addr_hold", memAddr, a);
            end
            memDone = 1'b1; memRdata = rd;
            @(posedge clk); #1;
            memDone = 1'b0; memRdata = $urandom;
            check("done", 32'(LSdone), 32'd1);
            check("done_latency", 32'(cyc - t_issue), 32'(2 + k));
            check("wrt", 32'(enLSwrt), 32'(ld));
            check("req_drop", 32'(memReq), 32'd0);
            if (ld) begin
                check("ldata", LSdata, ref_ext(op, rd));
                check("ltag", 32'(LStag), 32'(tg));
                check("lname", 32'(LSname), 32'(nm));
            end else begin
                check("st_tag_free", 32'(LStag), 32'(TAG_FREE));
                check("st_data_free", LSdata, DATA_FREE);
            end
        end
        @(posedge clk); #1;
        check("done_pulse", 32'(LSdone), 32'd0);
        check("wrt_pulse", 32'(enLSwrt), 32'd0);
        check("readen_after", 32'(LSreadEn), 32'd1);
    endtask

    logic [5:0] ops [8];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ops[0] = OP_LB; ops[1] = OP_LH; ops[2] = OP_LW; ops[3] = OP_LBU;
        ops[4] = OP_LHU; ops[5] = OP_SB; ops[6] = OP_SH; ops[7] = OP_SW;
        rst = 1'b1; LSworkEn = 1'b0; operandO = '0; operandT = '0; imm = '0;
        wrtTag = '0; wrtName = '0; opCode = '0; memDone = 1'b0; memRdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(memReq), 32'd0);
        check("rst_done", 32'(LSdone), 32'd0);
        check("rst_wrt", 32'(enLSwrt), 32'd0);
        check("rst_we", 32'(memWe), 32'd0);
        check("rst_len", 32'(memLen), 32'd0);
        check("rst_addr", memAddr, DATA_FREE);
        check("rst_wdata", memWdata, DATA_FREE);
        check("rst_ldata", LSdata, DATA_FREE);
        check("rst_tag", 32'(LStag), 32'(TAG_FREE));
        check("rst_name", 32'(LSname), 32'(NAME_FREE));
        check("rst_mis", 32'(LSmisalign), 32'd0);
        check("rst_readen", 32'(LSreadEn), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // directed
        do_op(OP_LW,  32'h100, 32'h4, 32'h0, 4'd3, 5'd5, 2, 32'hDEADBEEF, 1'b0);
        do_op(OP_LB,  32'h40,  32'h0, 32'h0, 4'd1, 5'd7, 1, 32'h00000080, 1'b0);
        do_op(OP_LBU, 32'h41,  32'h0, 32'h0, 4'd2, 5'd8, 0, 32'h00000080, 1'b0);
        do_op(OP_LH,  32'h42,  32'h0, 32'h0, 4'd9, 5'd9, 3, 32'h00008001, 1'b0);
        do_op(OP_LHU, 32'h44,  32'h0, 32'h0, 4'd4, 5'd1, 0, 32'hFFFF8001, 1'b0);
        do_op(OP_SB,  32'h200, 32'h0, 32'h12345678, 4'd6, 5'd2, 1, 32'h0, 1'b0);
        do_op(OP_LW,  32'hFFFFFFFC, 32'h8, 32'h0, 4'd5, 5'd3, 0, 32'hCAFEF00D, 1'b0);
        do_op(6'h3F,  32'h10,  32'h0, 32'h0, 4'd7, 5'd4, 0, 32'h0, 1'b0);
        do_op(OP_LW,  32'h102, 32'h0, 32'h0, 4'd8, 5'd6, 1, 32'h55AA55AA, 1'b0);

        // back-to-back, memDone at k=0
        do_op(OP_SW, 32'h1000, 32'h0, 32'hA5A5A5A5, 4'd1, 5'd1, 0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++)
            do_op(ops[i], 32'h2000 + 32'(4 * i), 32'h0, $urandom, 4'(i), 5'(i), 0, $urandom, 1'b1);

        // LSworkEn during MEM must be ignored
        do_op(OP_SH, 32'h10, 32'h0, 32'h0, 4'd0, 5'd0, 0, 32'h0, 1'b0);
        LSworkEn = 1'b1; opCode = OP_LW; operandO = 32'h300; imm = 32'h0;
        wrtTag = 4'd2; wrtName = 5'd2;
        @(posedge clk); #1;
        LSworkEn = 1'b1; opCode = OP_SW; operandO = 32'h500;
        @(posedge clk); #1;
        LSworkEn = 1'b0;
        check("viol_addr", memAddr, 32'h300);
        check("viol_we", 32'(memWe), 32'd0);
        check("viol_req", 32'(memReq), 32'd1);
        memDone = 1'b1; memRdata = 32'h11;
        @(posedge clk); #1;
        memDone = 1'b0;
        check("viol_done", 32'(LSdone), 32'd1);
        check("viol_data", LSdata, 32'h11);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("viol_no_second", 32'(memReq), 32'd0);

        // reset in the middle of MEM
        LSworkEn = 1'b1; opCode = OP_LW; operandO = 32'h400; imm = 32'h0;
        @(posedge clk); #1;
        LSworkEn = 1'b0;
        check("rmid_req", 32'(memReq), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rmid_req_drop", 32'(memReq), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rmid_no_done", 32'(LSdone), 32'd0);
            check("rmid_idle", 32'(LSreadEn), 32'd1);
        end

        // randomized
        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? 6'h3E : ops[$urandom_range(0, 7)];
            do_op(op, $urandom, (i % 4 == 0) ? $urandom : 32'($urandom_range(0, 64)),
                  $urandom, 4'($urandom), 5'($urandom), $urandom_range(0, 3), $urandom, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
